seq_div48by16: RTL and testbench
================================

# seq_div48by16

Sequential signed divider that inverts the `dsp_triple16mul` datapath. It divides a signed 48-bit value, such as a triple product, by a signed 16-bit factor and returns a signed 48-bit quotient and a signed 16-bit remainder. The uncertainty-propagation pipeline uses it wherever a term must be normalised by a 16-bit quantity. It is a restoring divider: it produces one quotient bit per cycle and handles signs by the same magnitude/sign-XOR scheme used by the multiplier.

## Interface
- No parameters; widths fixed at 48/16.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while idle.
- `dividend`  in  48  signed two's-complement dividend; captured on accepted start.
- `divisor`  in  16  signed two's-complement divisor; captured on accepted start.
- `quotient`  out  48  signed quotient, truncated toward zero.
- `remainder`  out  16  signed remainder; sign follows dividend.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse; results valid from this cycle onward.
- `div_zero`  out  1  divisor was zero; valid with `done`.
- `overflow`  out  1  quotient not representable; valid with `done`.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**, on `start`=1:
  - Capture `|dividend|` as 48-bit unsigned and `|divisor|` as 16-bit unsigned. -2^47 and -32768 map to unsigned 2^47 and 32768.
  - Capture `sign_q = dividend[47]^divisor[15]` and `sign_r = dividend[47]`.
  - Clear the 17-bit partial remainder. Set the step counter to 47. Go to RUN.
- **RUN**, one step per cycle:
  - Shift the partial remainder left, bringing in the next dividend magnitude bit, MSB first.
  - Trial-subtract the divisor magnitude. If there is no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter 0 → FIX.
- **FIX**, one cycle:
  - Quotient = `sign_q` ? −mag : mag. Remainder = `sign_r` ? −rem : rem.
  - Register the outputs and flags, pulse `done`, return to IDLE.
- Divide by zero:
  - RUN still executes its full 48 steps, so latency is constant.
  - In FIX: `div_zero`=1; quotient = 48'h7FFF_FFFF_FFFF if dividend ≥ 0, else 48'h8000_0000_0000; remainder = dividend[15:0].
- Overflow (only -2^47 / -1): `overflow`=1, quotient = 48'h7FFF_FFFF_FFFF, remainder = 0.
- The remainder magnitude is always below the divisor magnitude (< 2^15 for a nonzero divisor), so it never overflows 16 bits.
- `start` while `busy` is ignored; inputs may change freely during RUN.
- `quotient`, `remainder`, `div_zero` and `overflow` hold their values until the next FIX.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_zero`=0, `overflow`=0; state IDLE.
- Accepted start at edge k:
  - `busy`=1 after edge k.
  - RUN steps occupy edges k+1 … k+48.
  - FIX at edge k+49 drives `done`=1 and `busy`=0 for the cycle after k+49.
  - Fixed latency: 49 cycles start → done.
- Back-to-back: `start`=1 during the `done` cycle is accepted at edge k+50, because the state is already IDLE. Throughput is one division per 50 cycles.
- `rst` at any edge, including mid-RUN, aborts the operation and returns all outputs to reset values on that edge. No `done` is produced for the aborted operation. `rst` has priority over `start`.

## Test plan
- 1,000,000 / 7 → `quotient`=142857 (48'h0000_0002_2E09), `remainder`=1, `done` exactly 49 cycles after start, flags 0.
- -1,000,000 / 7 → `quotient`=48'hFFFF_FFFD_D1F7, `remainder`=16'hFFFF; 1,000,000 / -7 → `quotient`=48'hFFFF_FFFD_D1F7, `remainder`=1.
- Round trip of multiplier output: -3,000,000 (300·-200·50) / 50 → `quotient`=-60000 (48'hFFFF_FFFF_15A0), `remainder`=0.
- 1234 / 0 → `div_zero`=1, `quotient`=48'h7FFF_FFFF_FFFF, `remainder`=1234, latency still 49.
- Edge cases:
  - 48'h8000_0000_0000 / -1 → `overflow`=1, `quotient`=48'h7FFF_FFFF_FFFF.
  - Same dividend / 1 → `quotient`=48'h8000_0000_0000, flags 0.
  - Any dividend / -32768 → correct quotient.
- Control:
  - `start` pulsed at cycle 10 of RUN is ignored; result matches the first operands.
  - `rst` at cycle 20 of RUN → all outputs 0 next cycle, no `done`.
  - A new start immediately after reset completes normally.

Source files
------------

// File: rtl/seq_div48by16_if.sv
// rtl/seq_div48by16_if.sv - request/result bundle for the 48/16 sequential divider
//
// Purpose: groups the operand request and the result/status signals of
// seq_div48by16 so that requester and divider connect through one port.
// Signals:
//   start      request pulse, sampled by the divider only while idle
//   dividend   48-bit signed dividend
//   divisor    16-bit signed divisor
//   quotient   48-bit signed quotient, truncated toward zero
//   remainder  16-bit signed remainder, sign follows dividend
//   busy       division in progress
//   done       one-cycle completion pulse
//   div_zero   divisor was zero (valid with done)
//   overflow   quotient not representable (valid with done)
// Modports: master = requester side, slave = divider side.

interface seq_div48by16_if;
   logic        start;
   logic [47:0] dividend;
   logic [15:0] divisor;
   logic [47:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic        overflow;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_zero, overflow
   );
endinterface

// File: rtl/seq_div48by16.sv
// rtl/seq_div48by16.sv - sequential signed restoring divider, 48-bit by 16-bit
//
// Purpose: divides a signed 48-bit dividend by a signed 16-bit divisor, one
// quotient bit per cycle, using magnitudes plus a sign fix-up at the end.
// Latency from accepted start to done is a constant 49 cycles, including
// divide-by-zero.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset, priority over everything
//   bus   seq_div48by16_if.slave: start/dividend/divisor in,
//         quotient/remainder/busy/done/div_zero/overflow out

module seq_div48by16 (
   input logic           clk,
   input logic           rst,
   seq_div48by16_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t stateNext;

   // Working registers. quoShift starts as the dividend magnitude; each RUN
   // step shifts its MSB into the partial remainder and a quotient bit into
   // its LSB, so after 48 steps it holds the quotient magnitude.
   logic [47:0] quoShift;
   logic [15:0] partRem;
   logic [15:0] divMag;
   logic [5:0]  stepCnt;
   logic        signQ;
   logic        signR;
   logic        zeroDiv;
   logic        ovfCase;
   logic [15:0] dividendLow;

   // Registered outputs
   logic [47:0] quotientReg;
   logic [15:0] remainderReg;
   logic        busyReg;
   logic        doneReg;
   logic        divZeroReg;
   logic        overflowReg;

   // Operand magnitudes; two's-complement negation of the most negative
   // value yields the correct unsigned magnitude (2^47 / 32768).
   logic [47:0] dividendMag;
   logic [15:0] divisorMag;
   logic        accept;

   // One RUN step
   logic [16:0] shifted;
   logic        noBorrow;
   logic [15:0] trialDiff;

   // FIX results
   logic [47:0] fixQuotient;
   logic [15:0] fixRemainder;

   always_comb begin
      accept      = (state == IDLE) && bus.start;
      dividendMag = bus.dividend[47] ? (48'd0 - bus.dividend) : bus.dividend;
      divisorMag  = bus.divisor[15]  ? (16'd0 - bus.divisor)  : bus.divisor;
   end

   // The partial remainder stays below the divisor magnitude (<= 32768), so
   // after the shift it needs 17 bits; a successful trial subtraction brings
   // it back under 2^16, so only the low 16 bits of the difference are kept.
   always_comb begin
      shifted   = {partRem, quoShift[47]};
      noBorrow  = (shifted >= {1'b0, divMag});
      trialDiff = shifted[15:0] - divMag;
   end

   always_comb begin
      fixQuotient  = signQ ? (48'd0 - quoShift) : quoShift;
      fixRemainder = signR ? (16'd0 - partRem)  : partRem;
      if (zeroDiv) begin
         fixQuotient  = signR ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
         fixRemainder = dividendLow;
      end else if (ovfCase) begin
         fixQuotient  = 48'h7FFF_FFFF_FFFF;
         fixRemainder = 16'd0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.start) stateNext = RUN;
         RUN:     if (stepCnt == 6'd0) stateNext = FIX;
         FIX:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         quoShift     <= 48'd0;
         partRem      <= 16'd0;
         divMag       <= 16'd0;
         stepCnt      <= 6'd0;
         signQ        <= 1'b0;
         signR        <= 1'b0;
         zeroDiv      <= 1'b0;
         ovfCase      <= 1'b0;
         dividendLow  <= 16'd0;
         quotientReg  <= 48'd0;
         remainderReg <= 16'd0;
         busyReg      <= 1'b0;
         doneReg      <= 1'b0;
         divZeroReg   <= 1'b0;
         overflowReg  <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  quoShift    <= dividendMag;
                  partRem     <= 16'd0;
                  divMag      <= divisorMag;
                  stepCnt     <= 6'd47;
                  signQ       <= bus.dividend[47] ^ bus.divisor[15];
                  signR       <= bus.dividend[47];
                  zeroDiv     <= (bus.divisor == 16'd0);
                  ovfCase     <= (bus.dividend == 48'h8000_0000_0000) &&
                                 (bus.divisor == 16'hFFFF);
                  dividendLow <= bus.dividend[15:0];
                  busyReg     <= 1'b1;
               end
            end
            RUN: begin
               // With a zero divisor every trial succeeds; the result is
               // discarded in FIX, but the steps still run for fixed latency.
               partRem  <= noBorrow ? trialDiff : shifted[15:0];
               quoShift <= {quoShift[46:0], noBorrow};
               stepCnt  <= stepCnt - 6'd1;
            end
            FIX: begin
               quotientReg  <= fixQuotient;
               remainderReg <= fixRemainder;
               divZeroReg   <= zeroDiv;
               overflowReg  <= ovfCase;
               doneReg      <= 1'b1;
               busyReg      <= 1'b0;
            end
            default: begin
               busyReg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.quotient  = quotientReg;
   assign bus.remainder = remainderReg;
   assign bus.busy      = busyReg;
   assign bus.done      = doneReg;
   assign bus.div_zero  = divZeroReg;
   assign bus.overflow  = overflowReg;

endmodule

// File: tb/tb_seq_div48by16.sv
// tb/tb_seq_div48by16.sv - directed table-driven bench for seq_div48by16

module tb_seq_div48by16;

   logic clk;
   logic rst;

   seq_div48by16_if bus ();

   seq_div48by16 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] dd;
      logic [15:0] dv;
      logic [47:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
   } vec_t;

   localparam int NVEC = 14;
   localparam int LATENCY = 49;
   localparam int BUDGET = 60;

   vec_t vecs [NVEC];
   int   nChecks;
   int   nFails;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives start for one edge (caller must be away from the clock edge),
   // then counts cycles until done is seen #1 after an edge.
   task automatic runDiv(input logic [47:0] dd, input logic [15:0] dv,
                         output int lat, output logic busyOk);
      bus.dividend = dd;
      bus.divisor  = dv;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      busyOk    = bus.busy;
      lat       = 0;
      while (lat < BUDGET) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done) break;
         if (!bus.busy) busyOk = 1'b0;
      end
   endtask

   task automatic checkResult(input string tag, input vec_t v, input int lat, input logic busyOk);
      check({tag, " latency"},  48'(lat), 48'(LATENCY));
      check({tag, " busy"},     48'(busyOk), 48'd1);
      check({tag, " quotient"}, bus.quotient, v.q);
      check({tag, " remainder"},48'(bus.remainder), 48'(v.r));
      check({tag, " div_zero"}, 48'(bus.div_zero), 48'(v.dz));
      check({tag, " overflow"}, 48'(bus.overflow), 48'(v.ov));
      check({tag, " done-busy"},48'(bus.busy), 48'd0);
   endtask

   initial begin
      int   lat;
      logic busyOk;
      int   seen;
      vec_t v;

      nChecks = 0;
      nFails  = 0;

      vecs[0]  = '{48'h0000_000F_4240, 16'h0007, 48'h0000_0002_2E09, 16'h0001, 1'b0, 1'b0};
      vecs[1]  = '{48'hFFFF_FFF0_BDC0, 16'h0007, 48'hFFFF_FFFD_D1F7, 16'hFFFF, 1'b0, 1'b0};
      vecs[2]  = '{48'h0000_000F_4240, 16'hFFF9, 48'hFFFF_FFFD_D1F7, 16'h0001, 1'b0, 1'b0};
      vecs[3]  = '{48'hFFFF_FFD2_3940, 16'h0032, 48'hFFFF_FFFF_15A0, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{48'h0000_0000_04D2, 16'h0000, 48'h7FFF_FFFF_FFFF, 16'h04D2, 1'b1, 1'b0};
      vecs[5]  = '{48'h8000_0000_0000, 16'hFFFF, 48'h7FFF_FFFF_FFFF, 16'h0000, 1'b0, 1'b1};
      vecs[6]  = '{48'h8000_0000_0000, 16'h0001, 48'h8000_0000_0000, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{48'h8000_0000_0000, 16'h8000, 48'h0000_0001_0000_0000, 16'h0000, 1'b0, 1'b0};
      vecs[8]  = '{48'h0000_0001_86A0, 16'h8000, 48'hFFFF_FFFF_FFFD, 16'h06A0, 1'b0, 1'b0};
      vecs[9]  = '{48'hFFFF_FFFF_FB2E, 16'h0000, 48'h8000_0000_0000, 16'hFB2E, 1'b1, 1'b0};
      vecs[10] = '{48'h0000_0000_0000, 16'h0005, 48'h0000_0000_0000, 16'h0000, 1'b0, 1'b0};
      vecs[11] = '{48'h7FFF_FFFF_FFFF, 16'h7FFF, 48'h0000_0001_0002_0004, 16'h0003, 1'b0, 1'b0};
      vecs[12] = '{48'hFFFF_FFFF_FFF9, 16'h0002, 48'hFFFF_FFFF_FFFD, 16'hFFFF, 1'b0, 1'b0};
      vecs[13] = '{48'h0000_0000_0005, 16'hFFF9, 48'h0000_0000_0000, 16'h0005, 1'b0, 1'b0};

      bus.start    = 1'b0;
      bus.dividend = 48'd0;
      bus.divisor  = 16'd0;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("reset quotient",  bus.quotient, 48'd0);
      check("reset remainder", 48'(bus.remainder), 48'd0);
      check("reset busy",      48'(bus.busy), 48'd0);
      check("reset done",      48'(bus.done), 48'd0);
      check("reset div_zero",  48'(bus.div_zero), 48'd0);
      check("reset overflow",  48'(bus.overflow), 48'd0);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         runDiv(vecs[i].dd, vecs[i].dv, lat, busyOk);
         checkResult($sformatf("vec%0d", i), vecs[i], lat, busyOk);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d done pulse", i), 48'(bus.done), 48'd0);
         check($sformatf("vec%0d hold q", i), bus.quotient, vecs[i].q);
      end

      // start pulsed mid-RUN with new operands is ignored
      @(negedge clk);
      bus.dividend = vecs[0].dd;
      bus.divisor  = vecs[0].dv;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus.dividend = 48'h0000_0000_0005;
      bus.divisor  = 16'h0001;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 11;
      while (lat < BUDGET) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done) break;
      end
      checkResult("ignored start", vecs[0], lat, 1'b1);

      // back-to-back: start held in the done cycle is accepted on the next edge
      runDiv(vecs[12].dd, vecs[12].dv, lat, busyOk);
      checkResult("back2back", vecs[12], lat, busyOk);

      // reset mid-RUN aborts, clears outputs, no done
      @(negedge clk);
      bus.dividend = vecs[3].dd;
      bus.divisor  = vecs[3].dv;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort quotient",  bus.quotient, 48'd0);
      check("abort remainder", 48'(bus.remainder), 48'd0);
      check("abort busy",      48'(bus.busy), 48'd0);
      check("abort flags",     48'({bus.div_zero, bus.overflow, bus.done}), 48'd0);
      seen = 0;
      repeat (BUDGET) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) seen++;
      end
      check("abort no done", 48'(seen), 48'd0);

      // new start after reset completes normally
      v = vecs[8];
      runDiv(v.dd, v.dv, lat, busyOk);
      checkResult("after reset", v, lat, busyOk);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
